// File: rtl/bcd_display_scanner.sv
// Multiplexed 7-segment driver: snapshots a packed BCD word on load and scans
// its digits one at a time onto a common-segment display, with optional leading-zero blanking.
module bcd_display_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic                          load,
  input  logic                          enable,
  input  logic                          blank_lz,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PW    = $clog2(CLK_DIV);

  localparam logic [PW-1:0]         PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                     : {NUM_DIGITS{1'b0}};

  logic [4*NUM_DIGITS-1:0] r_snap;
  logic [PW-1:0]           r_presc;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_frame_done;
  logic [6:0]              r_seg_p1;
  logic [NUM_DIGITS-1:0]   r_an_p1;

  logic                    w_tick;
  logic [3:0]              w_nib;
  logic                    w_blank;
  logic [6:0]              w_seg_act;
  logic [NUM_DIGITS-1:0]   w_an_act;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  // Digit idx is a leading zero when it and every more-significant nibble are zero;
  // digit 0 is never considered, so a zero value still shows "0".
  function automatic logic lz_blank(input logic [4*NUM_DIGITS-1:0] snap,
                                    input logic [IDX_W-1:0]        idx);
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (snap[4*k +: 4] == 4'd0);
      if (idx == IDX_W'(k)) lz_blank = zero_above;
    end
  endfunction

  assign w_tick = enable && (r_presc == PRESC_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap <= '0;
    end else if (load) begin
      r_snap <= digits_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_tick && (r_idx == IDX_MAX);
      if (enable) begin
        r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
      end
      if (w_tick) begin
        r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_nib    = 4'd0;
    w_an_act = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib       = r_snap[4*k +: 4];
        w_an_act[k] = enable;
      end
    end
  end

  assign w_blank   = blank_lz && lz_blank(r_snap, r_idx);
  assign w_seg_act = (!enable || w_blank) ? 7'h00 : seg_decode(w_nib);

  // Output stage: one register of lag, polarity applied on the way in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_p1 <= SEG_OFF;
      r_an_p1  <= AN_OFF;
    end else begin
      r_seg_p1 <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_act : w_seg_act;
      r_an_p1  <= (AN_ACTIVE_LOW != 0)  ? ~w_an_act  : w_an_act;
    end
  end

  assign seg        = r_seg_p1;
  assign an         = r_an_p1;
  assign digit_idx  = r_idx;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomised bench for bcd_display_scanner: two instances (active-high and inverted
// polarity) share stimulus and are checked against a count-based behavioural model.
module tb_bcd_display_scanner;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits_in = '0;
  logic        load = 1'b0;
  logic        enable = 1'b0;
  logic        blank_lz = 1'b0;

  logic [6:0]  seg, seg_i;
  logic [3:0]  an, an_i;
  logic [1:0]  digit_idx, digit_idx_i;
  logic        frame_done, frame_done_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: snapshot value and number of enabled cycles since reset.
  int unsigned m_snap = 0;
  int unsigned m_cnt  = 0;

  bcd_display_scanner #(.NUM_DIGITS(N), .CLK_DIV(DIV), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .load(load), .enable(enable),
    .blank_lz(blank_lz), .seg(seg), .an(an), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  bcd_display_scanner #(.NUM_DIGITS(N), .CLK_DIV(DIV), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_inv (
    .clk(clk), .rst(rst), .digits_in(digits_in), .load(load), .enable(enable),
    .blank_lz(blank_lz), .seg(seg_i), .an(an_i), .digit_idx(digit_idx_i), .frame_done(frame_done_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [6:0] glyph(input int unsigned d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int unsigned snap, input int k, input bit blz);
    int unsigned upper;
    upper = snap >> (4 * k);
    if (blz && k > 0 && upper == 0) return 7'h00;
    return glyph(upper % 16);
  endfunction

  function automatic int model_idx();
    return int'((m_cnt / DIV) % N);
  endfunction

  task automatic check_outputs(input string tag, input logic [6:0] es, input logic [3:0] ea,
                               input int ei, input bit ef);
    chk({tag, "_seg"}, 32'(seg), 32'(es));
    chk({tag, "_an"}, 32'(an), 32'(ea));
    chk({tag, "_idx"}, 32'(digit_idx), 32'(ei));
    chk({tag, "_fd"}, 32'(frame_done), 32'(ef));
    chk({tag, "_seg_inv"}, 32'(seg_i), 32'(~es & 7'h7F));
    chk({tag, "_an_inv"}, 32'(an_i), 32'(~ea & 4'hF));
  endtask

  // One clock: predict registered outputs from pre-edge state and inputs, advance model, compare.
  task automatic step(input string tag);
    logic [6:0] es;
    logic [3:0] ea;
    bit         ef;
    int         k;
    k  = model_idx();
    es = enable ? model_seg(m_snap, k, blank_lz) : 7'h00;
    ea = enable ? 4'(1 << k) : 4'h0;
    ef = enable && (m_cnt % DIV == DIV - 1) && (k == N - 1);
    if (load) m_snap = 32'(digits_in);
    if (enable) m_cnt++;
    @(posedge clk);
    #1;
    check_outputs(tag, es, ea, model_idx(), ef);
  endtask

  // Reset pulse placed between clock edges; outputs must clear without a clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    m_snap = 0;
    m_cnt  = 0;
    check_outputs("arst", 7'h00, 4'h0, 0, 1'b0);
    #1 rst = 1'b0;
  endtask

  task automatic load_val(input logic [15:0] v);
    digits_in = v;
    load      = 1'b1;
    step("load");
    load      = 1'b0;
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    case ($urandom % 4)
      0: v = 16'($urandom);
      1: begin
        v = '0;
        for (int d = 0; d < N; d++) v[4*d +: 4] = 4'($urandom % 10);
        v = v >> (4 * ($urandom % 5));
      end
      2: v = 16'h0000;
      default: v = 16'($urandom % 16) << (4 * ($urandom % 4));
    endcase
    return v;
  endfunction

  initial begin
    #2 rst = 1'b1;
    #1;
    check_outputs("reset", 7'h00, 4'h0, 0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Plain scan of 0x1234
    enable = 1'b1;
    load_val(16'h1234);
    for (int i = 0; i < 34; i++) step("scan1234");

    // Leading-zero blanking, then all-zero value
    blank_lz = 1'b1;
    load_val(16'h0050);
    for (int i = 0; i < 17; i++) step("lz0050");
    load_val(16'h0000);
    for (int i = 0; i < 17; i++) step("lz0000");

    // Invalid nibble counts as non-zero and shows a dash
    load_val(16'h9A07);
    for (int i = 0; i < 17; i++) step("dash9A07");

    // Freeze mid-digit 2, then resume
    blank_lz = 1'b0;
    async_reset();
    load_val(16'h1234);
    while (m_cnt != 2 * DIV + 1) step("pre_hold");
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("hold");
      chk("hold_idx", 32'(digit_idx), 32'd2);
      chk("hold_an", 32'(an), 32'd0);
    end
    enable = 1'b1;
    for (int i = 0; i < 12; i++) step("resume");

    // Load coinciding with a tick
    load_val(16'h1111);
    for (int i = 0; i < 40 && (m_cnt % DIV) != DIV - 1; i++) step("pre_ldtick");
    digits_in = 16'h2222;
    load      = 1'b1;
    step("ldtick");
    load      = 1'b0;
    step("ldtick_next");
    chk("ldtick_seg", 32'(seg), 32'h5B);
    for (int i = 0; i < 8; i++) step("post_ldtick");

    // Mid-scan asynchronous reset, restart at digit 0
    step("pre_arst");
    step("pre_arst");
    async_reset();
    step("post_arst");
    chk("post_arst_seg", 32'(seg), 32'h3F);
    chk("post_arst_an", 32'(an), 32'h1);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      load      = ($urandom % 6 == 0);
      digits_in = rand_digits();
      if ($urandom % 25 == 0) enable   = ~enable;
      if ($urandom % 15 == 0) blank_lz = ~blank_lz;
      step("rand");
      if ($urandom % 250 == 0) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
